// File: rtl/door_pkg.sv
// ----------------------------------------------------------------------------
// door_pkg
// Shared definitions for the door sequencer: the FSM state encoding and the
// helpers used to size counters from parameters.
// No ports (package).
// ----------------------------------------------------------------------------
package door_pkg;

   typedef enum logic [1:0] {
      ST_CLOSED  = 2'd0,
      ST_OPENING = 2'd1,
      ST_OPEN    = 2'd2,
      ST_CLOSING = 2'd3
   } door_state_t;

   // Bits needed to hold values 0..max_val; never less than one bit.
   function automatic int cnt_w(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/door_sequencer_if.sv
// ----------------------------------------------------------------------------
// door_sequencer_if
// Request/sensor inputs and motor/status outputs of the door sequencer.
//   open_req    : request to open or reopen
//   close_req   : request to close early while open
//   obstruct    : obstruction sensor level, high = blocked
//   moving      : car-in-motion level, inhibits opening
//   motor_open  : drive door open
//   motor_close : drive door closed
//   door_closed : door fully closed, car may move
//   done        : one-cycle pulse when a door cycle completes
//   err         : sticky fault, motion seen while door not closed
// master = the controller/environment side, slave = the sequencer.
// ----------------------------------------------------------------------------
interface door_sequencer_if;

   logic open_req;
   logic close_req;
   logic obstruct;
   logic moving;
   logic motor_open;
   logic motor_close;
   logic door_closed;
   logic done;
   logic err;

   modport master (
      output open_req, close_req, obstruct, moving,
      input  motor_open, motor_close, door_closed, done, err
   );

   modport slave (
      input  open_req, close_req, obstruct, moving,
      output motor_open, motor_close, door_closed, done, err
   );

endinterface

// File: rtl/door_sequencer_tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to a one-cycle timing tick every DIV cycles. The count
// restarts from zero whenever clr is high, so the owner can align the tick
// grid to the start of a timed interval.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   clr   : restart the count at zero on the next edge
//   tick  : high for the cycle in which the count equals DIV-1
// ----------------------------------------------------------------------------
module tick_prescaler
   import door_pkg::*;
#(
   parameter int DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int            PW   = cnt_w(DIV);
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clr || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + PW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/door_sequencer.sv
// ----------------------------------------------------------------------------
// door_sequencer
// Elevator door controller: CLOSED -> OPENING -> OPEN -> CLOSING -> CLOSED,
// with hold restart on obstruction/reopen, early close, reversal while
// closing, and a sticky fault when the car moves with the door not closed.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : door_sequencer_if.slave (requests/sensors in, motors/status out)
// Parameters: DIV (clk cycles per tick), MOVE_TICKS (travel time in ticks),
// HOLD_TICKS (dwell time fully open in ticks).
// ----------------------------------------------------------------------------
module door_sequencer
   import door_pkg::*;
#(
   parameter int DIV        = 50_000_000,
   parameter int MOVE_TICKS = 2,
   parameter int HOLD_TICKS = 3
) (
   input logic            clk,
   input logic            rst_n,
   door_sequencer_if.slave bus
);

   localparam int            TW        = cnt_w(max2(MOVE_TICKS, HOLD_TICKS));
   localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_TICKS - 1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TICKS - 1);

   door_state_t   state;
   door_state_t   state_nxt;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic          restart;
   logic          clr;
   logic          move_done;
   logic          hold_done;

   logic motor_open_d, motor_close_d, door_closed_d, done_d, err_d;
   logic motor_open_q, motor_close_q, door_closed_q, done_q, err_q;

   tick_prescaler #(.DIV(DIV)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .tick  (tick)
   );

   // The last tick of an interval is the one seen while tick_cnt already
   // holds N-1, so the transition edge closes exactly N*DIV cycles.
   assign move_done = tick && (tick_cnt == MOVE_LAST);
   assign hold_done = tick && (tick_cnt == HOLD_LAST);

   // Timing restarts on any state change and on a hold restart.
   assign clr = restart || (state_nxt != state);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_CLOSED;
         tick_cnt      <= '0;
         motor_open_q  <= 1'b0;
         motor_close_q <= 1'b0;
         door_closed_q <= 1'b1;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state <= state_nxt;
         if (clr) begin
            tick_cnt <= '0;
         end else if (tick && (state != ST_CLOSED)) begin
            // CLOSED is untimed; counting there would let tick_cnt wrap.
            tick_cnt <= tick_cnt + TW'(1);
         end
         motor_open_q  <= motor_open_d;
         motor_close_q <= motor_close_d;
         door_closed_q <= door_closed_d;
         done_q        <= done_d;
         err_q         <= err_d;
      end
   end

   always_comb begin
      state_nxt = state;
      restart   = 1'b0;
      case (state)
         ST_CLOSED: begin
            if (bus.open_req && !bus.moving) state_nxt = ST_OPENING;
         end
         ST_OPENING: begin
            if (move_done) state_nxt = ST_OPEN;
         end
         ST_OPEN: begin
            // Obstruction or reopen request keeps the door open and
            // outranks both the early close and the hold expiry.
            if (bus.obstruct || bus.open_req) begin
               restart = 1'b1;
            end else if (bus.close_req || hold_done) begin
               state_nxt = ST_CLOSING;
            end
         end
         ST_CLOSING: begin
            if (bus.obstruct || bus.open_req) begin
               state_nxt = ST_OPENING;
            end else if (move_done) begin
               state_nxt = ST_CLOSED;
            end
         end
         default: state_nxt = ST_CLOSED;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they line
   // up with the state register rather than lagging it by a cycle.
   always_comb begin
      motor_open_d  = (state_nxt == ST_OPENING);
      motor_close_d = (state_nxt == ST_CLOSING);
      door_closed_d = (state_nxt == ST_CLOSED);
      done_d        = (state == ST_CLOSING) && (state_nxt == ST_CLOSED);
      err_d         = err_q || (bus.moving && (state != ST_CLOSED));
   end

   assign bus.motor_open  = motor_open_q;
   assign bus.motor_close = motor_close_q;
   assign bus.door_closed = door_closed_q;
   assign bus.done        = done_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_door_sequencer.sv
// ----------------------------------------------------------------------------
// tb_door_sequencer
// Bench for door_sequencer with DIV=4, MOVE_TICKS=2, HOLD_TICKS=3. A
// cycle-countdown model tracks which phase the door is in and how many
// cycles remain; outputs are compared against it on every falling edge.
// Directed scenarios add literal expectations on both DUT and model.
// ----------------------------------------------------------------------------
module tb_door_sequencer;

   localparam int DIV        = 4;
   localparam int MOVE_TICKS = 2;
   localparam int HOLD_TICKS = 3;
   localparam int MOVE_CYC   = DIV * MOVE_TICKS;
   localparam int HOLD_CYC   = DIV * HOLD_TICKS;

   localparam int M_CLOSED  = 0;
   localparam int M_OPENING = 1;
   localparam int M_OPEN    = 2;
   localparam int M_CLOSING = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   door_sequencer_if bus ();

   door_sequencer #(
      .DIV        (DIV),
      .MOVE_TICKS (MOVE_TICKS),
      .HOLD_TICKS (HOLD_TICKS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   vectors     = 0;
   int   miscompares = 0;

   int   m_ph    = M_CLOSED;
   int   m_rem   = 0;
   logic m_done  = 1'b0;
   logic m_err   = 1'b0;
   logic m_valid = 1'b0;

   // Reference: phase plus remaining cycles in that phase.
   always @(posedge clk) begin : model
      int   ph;
      int   rem;
      logic dn;
      logic er;
      ph  = m_ph;
      rem = m_rem;
      dn  = 1'b0;
      er  = m_err;
      if (!rst_n) begin
         ph  = M_CLOSED;
         rem = 0;
         er  = 1'b0;
      end else begin
         if (bus.moving && (ph != M_CLOSED)) er = 1'b1;
         case (ph)
            M_CLOSED: begin
               if (bus.open_req && !bus.moving) begin
                  ph = M_OPENING; rem = MOVE_CYC;
               end
            end
            M_OPENING: begin
               rem = rem - 1;
               if (rem == 0) begin ph = M_OPEN; rem = HOLD_CYC; end
            end
            M_OPEN: begin
               if (bus.obstruct || bus.open_req) begin
                  rem = HOLD_CYC;
               end else if (bus.close_req) begin
                  ph = M_CLOSING; rem = MOVE_CYC;
               end else begin
                  rem = rem - 1;
                  if (rem == 0) begin ph = M_CLOSING; rem = MOVE_CYC; end
               end
            end
            default: begin
               if (bus.obstruct || bus.open_req) begin
                  ph = M_OPENING; rem = MOVE_CYC;
               end else begin
                  rem = rem - 1;
                  if (rem == 0) begin ph = M_CLOSED; dn = 1'b1; end
               end
            end
         endcase
      end
      m_ph    <= ph;
      m_rem   <= rem;
      m_done  <= dn;
      m_err   <= er;
      m_valid <= 1'b1;
   end

   function automatic logic [4:0] dut_vec();
      return {bus.motor_open, bus.motor_close, bus.door_closed, bus.done, bus.err};
   endfunction

   function automatic logic [4:0] model_vec();
      return {(m_ph == M_OPENING), (m_ph == M_CLOSING), (m_ph == M_CLOSED), m_done, m_err};
   endfunction

   // Every-cycle comparison, order {motor_open,motor_close,door_closed,done,err}.
   always @(negedge clk) begin
      if (m_valid) begin
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL cycle_compare t=%0t actual=%b required=%b", $time, dut_vec(), model_vec());
         end
      end
   end

   // Literal expectation applied to both the DUT and the model.
   task automatic lit(input string name, input logic [4:0] exp_v);
      vectors++;
      if (dut_vec() !== exp_v) begin
         miscompares++;
         $display("FAIL %s dut=%b required=%b", name, dut_vec(), exp_v);
      end
      vectors++;
      if (model_vec() !== exp_v) begin
         miscompares++;
         $display("FAIL %s_model model=%b required=%b", name, model_vec(), exp_v);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_inputs();
      bus.open_req  = 1'b0;
      bus.close_req = 1'b0;
      bus.obstruct  = 1'b0;
      bus.moving    = 1'b0;
   endtask

   task automatic pulse_open();
      bus.open_req = 1'b1;
      step(1);
      bus.open_req = 1'b0;
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;
      @(negedge clk);
      lit("reset_state", 5'b00100);

      // Full cycle: open_req sampled at edge 0, cycle c follows edge c-1.
      pulse_open();
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         lit($sformatf("seq_c%0d", c),
             {(c <= 8), (c >= 21 && c <= 28), (c >= 29), (c == 29), 1'b0});
         step(1);
      end

      // Obstruction held during OPEN, then released.
      pulse_open();
      step(MOVE_CYC);
      bus.obstruct = 1'b1;
      step(20);
      bus.obstruct = 1'b0;
      step(11);
      @(negedge clk);
      lit("obstruct_still_open", 5'b00000);
      step(1);
      @(negedge clk);
      lit("obstruct_then_close", 5'b01000);
      step(MOVE_CYC);
      @(negedge clk);
      lit("obstruct_done", 5'b00110);
      step(1);

      // Reversal in cycle 3 of CLOSING.
      pulse_open();
      step(MOVE_CYC + HOLD_CYC + 2);
      @(negedge clk);
      lit("closing_c3", 5'b01000);
      bus.obstruct = 1'b1;
      step(1);
      bus.obstruct = 1'b0;
      @(negedge clk);
      lit("reverse_open_c1", 5'b10000);
      step(7);
      @(negedge clk);
      lit("reverse_open_c8", 5'b10000);
      step(1);
      @(negedge clk);
      lit("reverse_open_end", 5'b00000);
      step(HOLD_CYC + MOVE_CYC);
      @(negedge clk);
      lit("reverse_final_done", 5'b00110);
      step(1);

      // Early close in the first OPEN cycle.
      pulse_open();
      step(MOVE_CYC);
      bus.close_req = 1'b1;
      step(1);
      bus.close_req = 1'b0;
      @(negedge clk);
      lit("early_close", 5'b01000);
      step(MOVE_CYC + 1);

      // close_req together with obstruct stays open.
      pulse_open();
      step(MOVE_CYC);
      bus.close_req = 1'b1;
      bus.obstruct  = 1'b1;
      step(1);
      clear_inputs();
      @(negedge clk);
      lit("close_vs_obstruct", 5'b00000);
      step(HOLD_CYC);
      @(negedge clk);
      lit("close_vs_obstruct_later", 5'b01000);
      step(MOVE_CYC + 1);

      // moving inhibits opening without fault; moving while open faults.
      bus.moving   = 1'b1;
      bus.open_req = 1'b1;
      step(1);
      clear_inputs();
      @(negedge clk);
      lit("moving_inhibit", 5'b00100);
      step(3);
      @(negedge clk);
      lit("moving_inhibit_later", 5'b00100);
      pulse_open();
      step(MOVE_CYC);
      bus.moving = 1'b1;
      step(1);
      bus.moving = 1'b0;
      @(negedge clk);
      lit("err_set", 5'b00001);
      step(HOLD_CYC + MOVE_CYC + 1);
      @(negedge clk);
      lit("err_sticky", 5'b00101);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      @(negedge clk);
      lit("err_cleared", 5'b00100);

      // Reset in the middle of OPENING.
      pulse_open();
      step(3);
      @(negedge clk);
      lit("opening_mid", 5'b10000);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      @(negedge clk);
      lit("reset_mid_open", 5'b00100);
      step(2);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         bus.open_req  = ($urandom_range(0, 11) == 0);
         bus.close_req = ($urandom_range(0, 15) == 0);
         bus.obstruct  = ($urandom_range(0, 19) == 0);
         bus.moving    = ($urandom_range(0, 399) == 0);
         rst_n         = ($urandom_range(0, 599) != 0);
         step(1);
      end
      clear_inputs();
      rst_n = 1'b1;
      step(2);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/door_sequencer.md
DOOR_SEQUENCER -- requirements
Module: door_sequencer

Interface
REQ-001 The block SHALL have parameter DIV, default 50_000_000: clk cycles per timing tick, legal range >= 1.
REQ-002 The block SHALL have parameter MOVE_TICKS, default 2: ticks the door motor runs to fully open or fully close, >= 1.
REQ-003 The block SHALL have parameter HOLD_TICKS, default 3: ticks the door dwells fully open, >= 1.
REQ-004 The block SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 The block SHALL have port open_req  input  1  request to open or reopen, sampled every cycle.
REQ-007 The block SHALL have port close_req  input  1  request to close early while open.
REQ-008 The block SHALL have port obstruct  input  1  level obstruction sensor, high = blocked.
REQ-009 The block SHALL have port moving  input  1  car-in-motion level; high inhibits opening.
REQ-010 The block SHALL have port motor_open  output  1  drive door open.
REQ-011 The block SHALL have port motor_close  output  1  drive door closed.
REQ-012 The block SHALL have port door_closed  output  1  door fully closed, car may move.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse when a door cycle completes.
REQ-014 The block SHALL have port err  output  1  sticky fault: moving seen while door not closed.

Function
REQ-015 The block SHALL contain a prescaler counting 0..DIV-1 and emitting an internal one-cycle tick when the count equals DIV-1; DIV=1 gives a tick every cycle.
REQ-016 The prescaler and the tick counter SHALL clear on every state transition and on hold restart, so a state lasts exactly N*DIV cycles for N ticks.
REQ-017 The tick counter width SHALL be $clog2(max(MOVE_TICKS,HOLD_TICKS)+1) bits; the prescaler width SHALL be $clog2(DIV+1) bits; neither SHALL wrap.
REQ-018 States SHALL be CLOSED, OPENING, OPEN and CLOSING; the state register updates on the clock edge at which inputs are sampled.
REQ-019 In CLOSED, open_req=1 with moving=0 SHALL enter OPENING; open_req with moving=1 SHALL be ignored.
REQ-020 In OPENING, after MOVE_TICKS ticks the state SHALL become OPEN; requests are ignored.
REQ-021 In OPEN, after HOLD_TICKS ticks with obstruct=0 the state SHALL become CLOSING.
REQ-022 In OPEN, close_req=1 with obstruct=0 SHALL enter CLOSING on the next edge.
REQ-023 In OPEN, obstruct=1 or open_req=1 SHALL restart the hold count and block closing; obstruct has priority over close_req.
REQ-024 In CLOSING, obstruct=1 or open_req=1 SHALL reverse to OPENING with a full MOVE_TICKS duration.
REQ-025 In CLOSING, after MOVE_TICKS ticks without reversal the state SHALL become CLOSED and done SHALL pulse high for exactly the first cycle in CLOSED.
REQ-026 Outputs SHALL be registered: motor_open=1 only in OPENING; motor_close=1 only in CLOSING; door_closed=1 only in CLOSED; motor_open and motor_close SHALL never both be 1.
REQ-027 Sampling moving=1 in any state other than CLOSED SHALL set err; err holds until reset and does not alter sequencing.

Reset
REQ-028 With rst_n=0 at a clock edge, the block SHALL enter CLOSED and clear the prescaler and tick counter.
REQ-029 Reset values SHALL be door_closed=1, motor_open=0, motor_close=0, done=0, err=0.
REQ-030 Reset asserted mid-operation SHALL abort the cycle immediately with no done pulse.

Structure
REQ-031 The state encoding typedef and a width helper function SHALL reside in shared package door_pkg.
REQ-032 The prescaler SHALL be sub-module tick_prescaler (parameter DIV; ports clk, rst_n, clr, tick).

Verification (DIV=4, MOVE_TICKS=2, HOLD_TICKS=3)
REQ-033 The bench SHALL check: open_req pulsed at edge 0 -> motor_open=1 for cycles 1-8, OPEN for cycles 9-20, motor_close=1 for cycles 21-28, done=1 only in cycle 29.
REQ-034 The bench SHALL check: obstruct held high for 20 cycles during OPEN -> door stays OPEN and closes 12 cycles after obstruct falls.
REQ-035 The bench SHALL check: obstruct pulsed in cycle 3 of CLOSING -> OPENING re-entered next cycle, lasting 8 cycles, with no done pulse.
REQ-036 The bench SHALL check: close_req in the first OPEN cycle -> CLOSING on the next cycle; close_req together with obstruct -> remains OPEN.
REQ-037 The bench SHALL check: open_req with moving=1 in CLOSED -> no motion and err=0; moving=1 during OPEN -> err=1 until rst_n=0.
REQ-038 The bench SHALL check: rst_n=0 in the middle of OPENING -> the next cycle shows door_closed=1, both motors=0 and done=0.
